// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse message player.
//   morse_state_t : playback controller state encoding
//   morse_sym_t   : encoded character {len, pat, space, skip}
//   DOT..WGAP_LOOP: durations in Morse units
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_ELEM_ON  = 3'd2,
      ST_ELEM_GAP = 3'd3,
      ST_CHAR_GAP = 3'd4,
      ST_WORD_GAP = 3'd5
   } morse_state_t;

   localparam int DOT        = 1;
   localparam int DASH       = 3;
   localparam int EGAP       = 1;
   localparam int CGAP       = 3;
   // A word gap is 7 units, 3 of which the preceding char gap already covers.
   localparam int WGAP_EXTRA = 4;
   localparam int WGAP_LOOP  = 7;

   // pat is left-aligned: element i of the character is pat[4-i], 1 = dash.
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
      logic       space;
      logic       skip;
   } morse_sym_t;

endpackage

// File: rtl/morse_char_rom.sv
// ASCII to Morse symbol lookup, purely combinational.
// Ports:
//   ch  : ASCII character
//   sym : encoded symbol; letters are case folded, 0x20 sets space,
//         anything without a Morse code sets skip
module morse_char_rom
   import morse_pkg::*;
(
   input  logic [7:0] ch,
   output morse_sym_t sym
);

   logic [7:0] up;
   logic [7:0] code;   // {len, pat}; zero means no Morse code

   always_comb begin
      up = ch;
      if (ch >= 8'h61 && ch <= 8'h7A) up = ch - 8'h20;
      code = 8'h00;
      case (up)
         "A": code = {3'd2, 5'b01000};
         "B": code = {3'd4, 5'b10000};
         "C": code = {3'd4, 5'b10100};
         "D": code = {3'd3, 5'b10000};
         "E": code = {3'd1, 5'b00000};
         "F": code = {3'd4, 5'b00100};
         "G": code = {3'd3, 5'b11000};
         "H": code = {3'd4, 5'b00000};
         "I": code = {3'd2, 5'b00000};
         "J": code = {3'd4, 5'b01110};
         "K": code = {3'd3, 5'b10100};
         "L": code = {3'd4, 5'b01000};
         "M": code = {3'd2, 5'b11000};
         "N": code = {3'd2, 5'b10000};
         "O": code = {3'd3, 5'b11100};
         "P": code = {3'd4, 5'b01100};
         "Q": code = {3'd4, 5'b11010};
         "R": code = {3'd3, 5'b01000};
         "S": code = {3'd3, 5'b00000};
         "T": code = {3'd1, 5'b10000};
         "U": code = {3'd3, 5'b00100};
         "V": code = {3'd4, 5'b00010};
         "W": code = {3'd3, 5'b01100};
         "X": code = {3'd4, 5'b10010};
         "Y": code = {3'd4, 5'b10110};
         "Z": code = {3'd4, 5'b11000};
         "0": code = {3'd5, 5'b11111};
         "1": code = {3'd5, 5'b01111};
         "2": code = {3'd5, 5'b00111};
         "3": code = {3'd5, 5'b00011};
         "4": code = {3'd5, 5'b00001};
         "5": code = {3'd5, 5'b00000};
         "6": code = {3'd5, 5'b10000};
         "7": code = {3'd5, 5'b11000};
         "8": code = {3'd5, 5'b11100};
         "9": code = {3'd5, 5'b11110};
         default: code = 8'h00;
      endcase
      sym.len   = code[7:5];
      sym.pat   = code[4:0];
      sym.space = (ch == 8'h20);
      sym.skip  = (ch != 8'h20) && (code[7:5] == 3'd0);
   end

endmodule

// File: rtl/morse_msg_player.sv
// Morse message player: plays a host-loaded ASCII buffer on an LED bank with
// ITU timing (dot 1, dash 3, element gap 1, char gap 3, word gap 7 units).
// Optional feature macro: MORSE_LOOP_EN (repeat the message while loop=1).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   wr_valid/wr_char   : append a char when wr_ready
//   wr_ready           : idle and buffer not full
//   clr                : empty the buffer (ignored while busy)
//   start, abort, loop : playback control
//   busy, done         : playback active, one-cycle completion pulse
//   key, led           : element sounding, replicated onto LED_W bits
//   count              : characters stored
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_FETCH    | one cycle: read and encode buf[idx]
// ST_ELEM_ON  | key on for a dot or dash
// ST_ELEM_GAP | 1-unit gap between elements
// ST_CHAR_GAP | 3-unit gap between characters
// ST_WORD_GAP | extra 4 units for a space, or 7 units before a loop restart
module morse_msg_player
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 6_250_000,
   parameter int MSG_DEPTH   = 16,
   parameter int LED_W       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_char,
   output logic                         wr_ready,
   input  logic                         clr,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         loop,
   output logic                         busy,
   output logic                         done,
   output logic                         key,
   output logic [LED_W-1:0]             led,
   output logic [$clog2(MSG_DEPTH):0]   count
);

   localparam int AW   = $clog2(MSG_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0] CYC_MAX = CW'(UNIT_CYCLES - 1);

   morse_state_t  state;
   logic [7:0]    buf_mem [MSG_DEPTH];
   logic [AW-1:0] idx;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    units_left;
   logic [4:0]    pat_sh;
   logic [2:0]    elems_left;
   logic          wrap;
   morse_sym_t    sym;
   logic          unit_end;
   logic          last_char;
   logic          loop_on;

   morse_char_rom u_rom (
      .ch  (buf_mem[idx]),
      .sym (sym)
   );

`ifdef MORSE_LOOP_EN
   assign loop_on = loop;
`else
   assign loop_on = loop & 1'b0;
`endif

   assign unit_end  = (cyc_cnt == '0) && (units_left == 3'd0);
   assign last_char = ((CNTW'(idx) + CNTW'(1)) == count);
   assign wr_ready  = !busy && (count < CNTW'(MSG_DEPTH));
   assign led       = {LED_W{key}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         idx        <= '0;
         cyc_cnt    <= '0;
         units_left <= '0;
         pat_sh     <= '0;
         elems_left <= '0;
         wrap       <= 1'b0;
         key        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < MSG_DEPTH; i++) buf_mem[i] <= 8'h00;
      end else begin
         done <= 1'b0;

         if (clr && !busy) begin
            count <= '0;
         end else if (wr_valid && wr_ready) begin
            buf_mem[count[AW-1:0]] <= wr_char;
            count                  <= count + CNTW'(1);
         end

         // Free-running unit timer; state entries below override with a reload.
         if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CW'(1);
         end else if (units_left != 3'd0) begin
            units_left <= units_left - 3'd1;
            cyc_cnt    <= CYC_MAX;
         end

         if (abort) begin
            state <= ST_IDLE;
            key   <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && count != '0) begin
                     state <= ST_FETCH;
                     idx   <= '0;
                     wrap  <= 1'b0;
                     busy  <= 1'b1;
                  end
               end

               ST_FETCH: begin
                  if (sym.skip) begin
                     if (!last_char) begin
                        idx <= idx + AW'(1);
                     end else if (loop_on) begin
                        state      <= ST_WORD_GAP;
                        wrap       <= 1'b1;
                        cyc_cnt    <= CYC_MAX;
                        units_left <= 3'(WGAP_LOOP - 1);
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else if (sym.space) begin
                     state      <= ST_WORD_GAP;
                     cyc_cnt    <= CYC_MAX;
                     units_left <= 3'(WGAP_EXTRA - 1);
                  end else begin
                     state      <= ST_ELEM_ON;
                     key        <= 1'b1;
                     pat_sh     <= sym.pat;
                     elems_left <= sym.len - 3'd1;
                     cyc_cnt    <= CYC_MAX;
                     units_left <= sym.pat[4] ? 3'(DASH - 1) : 3'(DOT - 1);
                  end
               end

               ST_ELEM_ON: begin
                  if (unit_end) begin
                     key <= 1'b0;
                     if (elems_left != 3'd0) begin
                        state      <= ST_ELEM_GAP;
                        pat_sh     <= {pat_sh[3:0], 1'b0};
                        elems_left <= elems_left - 3'd1;
                        cyc_cnt    <= CYC_MAX;
                        units_left <= 3'(EGAP - 1);
                     end else if (!last_char) begin
                        state      <= ST_CHAR_GAP;
                        cyc_cnt    <= CYC_MAX;
                        units_left <= 3'(CGAP - 1);
                     end else if (loop_on) begin
                        state      <= ST_WORD_GAP;
                        wrap       <= 1'b1;
                        cyc_cnt    <= CYC_MAX;
                        units_left <= 3'(WGAP_LOOP - 1);
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end

               ST_ELEM_GAP: begin
                  if (unit_end) begin
                     state      <= ST_ELEM_ON;
                     key        <= 1'b1;
                     cyc_cnt    <= CYC_MAX;
                     units_left <= pat_sh[4] ? 3'(DASH - 1) : 3'(DOT - 1);
                  end
               end

               ST_CHAR_GAP: begin
                  if (unit_end) begin
                     state <= ST_FETCH;
                     idx   <= idx + AW'(1);
                  end
               end

               ST_WORD_GAP: begin
                  if (unit_end) begin
                     if (wrap) begin
                        wrap  <= 1'b0;
                        idx   <= '0;
                        state <= ST_FETCH;
                     end else if (!last_char) begin
                        idx   <= idx + AW'(1);
                        state <= ST_FETCH;
                     end else if (loop_on) begin
                        wrap       <= 1'b1;
                        cyc_cnt    <= CYC_MAX;
                        units_left <= 3'(WGAP_LOOP - 1);
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end

               default: begin
                  state <= ST_IDLE;
                  key   <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_morse_msg_player.sv
// Testbench for morse_msg_player with UNIT_CYCLES=4. Expected key waveforms
// are built from a Morse dot/dash string table and the ITU timing rules.
module tb_morse_msg_player;

   localparam int U     = 4;
   localparam int DEPTH = 16;
   localparam int LW    = 8;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       wr_valid;
   logic [7:0]                 wr_char;
   logic                       wr_ready;
   logic                       clr;
   logic                       start;
   logic                       abort;
   logic                       loop;
   logic                       busy;
   logic                       done;
   logic                       key;
   logic [LW-1:0]              led;
   logic [$clog2(DEPTH):0]     count;

   morse_msg_player #(.UNIT_CYCLES(U), .MSG_DEPTH(DEPTH), .LED_W(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_char  (wr_char),
      .wr_ready (wr_ready),
      .clr      (clr),
      .start    (start),
      .abort    (abort),
      .loop     (loop),
      .busy     (busy),
      .done     (done),
      .key      (key),
      .led      (led),
      .count    (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_q[$];
   bit obs_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic string morse_of(input logic [7:0] c_in);
      logic [7:0] c;
      c = c_in;
      if (c >= "a" && c <= "z") c = c - 8'd32;
      case (c)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--...";  "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   task automatic push(input bit v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   // Key per cycle from the FETCH cycle after start up to (excluding) done.
   task automatic build_exp(input string msg);
      string m;
      exp_q.delete();
      for (int i = 0; i < msg.len(); i++) begin
         push(1'b0, 1);
         if (msg[i] == " ") begin
            push(1'b0, 4 * U);
         end else begin
            m = morse_of(msg[i]);
            if (m.len() > 0) begin
               for (int j = 0; j < m.len(); j++) begin
                  push(1'b1, (m[j] == "-") ? 3 * U : U);
                  if (j < m.len() - 1) push(1'b0, U);
               end
               if (i < msg.len() - 1) push(1'b0, 3 * U);
            end
         end
      end
   endtask

   task automatic load_msg(input string tag, input string msg);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < msg.len(); i++) begin
         wr_valid = 1'b1;
         wr_char  = msg[i];
         @(negedge clk);
      end
      wr_valid = 1'b0;
      check({tag, "_count"}, 32'(count), 32'(msg.len()));
   endtask

   // Pulses start and records key until done; restart_at >= 0 re-pulses start
   // at that sample index to show it is ignored while busy.
   task automatic play_check(input string tag, input string msg, input int restart_at);
      int done_at;
      int busy_low;
      int led_bad;
      int mism;
      logic busy_at_done;
      build_exp(msg);
      obs_q.delete();
      done_at = -1; busy_low = 0; led_bad = 0; mism = 0; busy_at_done = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         if (done) begin
            done_at      = k;
            busy_at_done = busy;
            break;
         end
         obs_q.push_back(key);
         if (!busy) busy_low++;
         if (led !== {LW{key}}) led_bad++;
         start = (k == restart_at);
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_q.size()));
      check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      check({tag, "_busy_low"}, 32'(busy_low), 32'd0);
      check({tag, "_led"}, 32'(led_bad), 32'd0);
      for (int k = 0; k < exp_q.size(); k++)
         if (k >= obs_q.size() || obs_q[k] != exp_q[k]) mism++;
      check({tag, "_key_wave"}, 32'(mism), 32'd0);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(done), 32'd0);
   endtask

   string pool;
   string msg;
   int    done_seen;
   int    mism;

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; clr = 1'b0;
      start = 1'b0; abort = 1'b0; loop = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_key",   32'(key),      32'd0);
      check("rst_led",   32'(led),      32'd0);
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_done",  32'(done),     32'd0);
      check("rst_count", 32'(count),    32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(wr_ready), 32'd1);

      // start with an empty buffer does nothing
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty_start_busy", 32'(busy), 32'd0);

      // clr wins over a simultaneous write
      load_msg("pre_clr", "AB");
      clr = 1'b1; wr_valid = 1'b1; wr_char = "Z";
      @(negedge clk);
      clr = 1'b0; wr_valid = 1'b0;
      check("clr_wins_count", 32'(count), 32'd0);

      load_msg("e", "E");       play_check("e", "E", -1);
      load_msg("a", "A");       play_check("a", "A", -1);
      load_msg("ee", "EE");     play_check("ee", "EE", -1);
      load_msg("e_e", "E E");   play_check("e_e", "E E", -1);
      play_check("e_e_replay", "E E", -1);
      load_msg("skip", "#E");   play_check("skip", "#E", -1);
      load_msg("restart", "ET"); play_check("restart", "ET", 10);

      // full buffer
      msg = "";
      for (int i = 0; i < DEPTH; i++) msg = {msg, (i % 2) ? "I" : "m"};
      load_msg("full", msg);
      check("full_ready", 32'(wr_ready), 32'd0);
      wr_valid = 1'b1; wr_char = "Q";
      @(negedge clk);
      wr_valid = 1'b0;
      check("full_drop_count", 32'(count), 32'(DEPTH));
      play_check("full", msg, -1);

      // abort mid-dash
      load_msg("abort", "T");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_pre_key", 32'(key), 32'd1);
      check("busy_ready", 32'(wr_ready), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_key",  32'(key),  32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || key) done_seen++;
         @(negedge clk);
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_buf_kept", 32'(count), 32'd1);
      play_check("abort_replay", "T", -1);

      // randomized messages
      pool = "AEIOTNSMKRQ019 #xz";
      for (int r = 0; r < 8; r++) begin
         msg = "";
         for (int i = 0; i < $urandom_range(1, 6); i++) begin
            msg = {msg, "?"};
            msg.putc(i, pool[$urandom_range(0, pool.len() - 1)]);
         end
         load_msg($sformatf("rnd%0d", r), msg);
         play_check($sformatf("rnd%0d", r), msg, -1);
      end

`ifdef MORSE_LOOP_EN
      load_msg("loop", "E");
      loop = 1'b1;
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         push(1'b0, 1); push(1'b1, U); push(1'b0, 7 * U);
      end
      obs_q.delete();
      done_seen = 0;
      mism = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (done || !busy) done_seen++;
         if (key != exp_q[k]) mism++;
         @(negedge clk);
      end
      check("loop_key_wave", 32'(mism), 32'd0);
      check("loop_no_done", 32'(done_seen), 32'd0);
      loop = 1'b0;
      done_seen = -1;
      for (int k = 0; k < 200; k++) begin
         if (done) begin
            done_seen = k;
            break;
         end
         @(negedge clk);
      end
      check("loop_drop_done", 32'(done_seen), 32'(1 + U));
`else
      load_msg("noloop", "E");
      loop = 1'b1;
      play_check("noloop", "E", -1);
      loop = 1'b0;
`endif

      // reset mid-playback clears the buffer
      load_msg("rst_mid", "O");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_key",   32'(key),   32'd0);
      check("rst_mid_busy",  32'(busy),  32'd0);
      check("rst_mid_count", 32'(count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
